// File: rtl/sc_ringosc_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sc_ringosc_meas_ctrl                                         |
// | Description : Ring-oscillator measurement scheduler. Enables the rings     |
// |               selected by a mask one at a time, lets each settle, counts   |
// |               its synchronised rising edges over a programmable gate       |
// |               window and hands each count out over valid/ready.            |
// | Ports       : clk_i/rst_ni        clock, async active-low reset            |
// |               start_i/abort_i     begin / cancel a sweep                   |
// |               mask_i, gate_cycles_i  sweep set-up, latched at start        |
// |               osc_i               divided ring outputs (async to clk_i)    |
// |               osc_en_o            one-hot ring enable                      |
// |               busy_o, done_o      sweep in progress / end-of-sweep pulse   |
// |               result_*            ring index and edge count, valid/ready   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sc_ringosc_meas_ctrl #(
   parameter int  NUM_OSC       = 8,
   parameter int  GATE_W        = 16,
   parameter int  CNT_W         = 20,
   parameter int  SETTLE_CYCLES = 16,
   localparam int IDX_W         = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [NUM_OSC-1:0] mask_i,
   input  logic [GATE_W-1:0]  gate_cycles_i,
   input  logic [NUM_OSC-1:0] osc_i,
   output logic [NUM_OSC-1:0] osc_en_o,
   output logic               busy_o,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [IDX_W-1:0]   result_idx_o,
   output logic [CNT_W-1:0]   result_cnt_o,
   output logic               done_o
);

   localparam int                 SET_W       = $clog2(SETTLE_CYCLES + 1);
   localparam int                 TMR_W       = (GATE_W > SET_W) ? GATE_W : SET_W;
   localparam logic [TMR_W-1:0]   SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [NUM_OSC-1:0] ONE_HOT0    = NUM_OSC'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GATE   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t             state_q;
   logic [NUM_OSC-1:0] mask_q;      // rings still to be measured in this sweep
   logic [NUM_OSC-1:0] osc_en_q;
   logic [NUM_OSC-1:0] sync1_q;
   logic [NUM_OSC-1:0] sync2_q;
   logic [NUM_OSC-1:0] sync3_q;     // edge-detect history
   logic [GATE_W-1:0]  gate_q;
   logic [TMR_W-1:0]   timer_q;     // cycles remaining in SETTLE/GATE, minus one
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               valid_q;
   logic               done_q;

   logic [NUM_OSC-1:0] pending_d;
   logic [IDX_W-1:0]   first_idx_d;
   logic [IDX_W-1:0]   next_idx_d;
   logic               edge_d;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_OSC-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_OSC - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Rings are visited in ascending order, so once the current ring is
   // dropped from the pending set the lowest remaining bit is the next one.
   assign pending_d   = mask_q & ~(ONE_HOT0 << idx_q);
   assign first_idx_d = lowest_idx(mask_i);
   assign next_idx_d  = lowest_idx(pending_d);

   // Rising-edge pulse of the selected ring after the two-flop synchroniser.
   // The pulse stream trails the pins by the pipeline depth; counting it for
   // exactly the GATE cycles gives a window of exactly GATE_CYCLES length.
   assign edge_d = sync2_q[idx_q] & ~sync3_q[idx_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= osc_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         osc_en_q <= '0;
         gate_q   <= GATE_W'(1);
         timer_q  <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != ST_IDLE && abort_i) begin
            state_q  <= ST_IDLE;
            osc_en_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     gate_q <= (gate_cycles_i == '0) ? GATE_W'(1) : gate_cycles_i;
                     if (mask_i == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        mask_q   <= mask_i;
                        idx_q    <= first_idx_d;
                        osc_en_q <= ONE_HOT0 << first_idx_d;
                        timer_q  <= SETTLE_LOAD;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETTLE;
                     end
                  end
               end
               ST_SETTLE: begin
                  cnt_q <= '0;
                  if (timer_q == '0) begin
                     timer_q <= TMR_W'(gate_q) - TMR_W'(1);
                     state_q <= ST_GATE;
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                  end
               end
               ST_GATE: begin
                  if (edge_d && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
                  if (timer_q == '0) begin
                     osc_en_q <= '0;
                     valid_q  <= 1'b1;
                     state_q  <= ST_REPORT;
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                  end
               end
               ST_REPORT: begin
                  if (result_ready_i) begin
                     valid_q <= 1'b0;
                     if (pending_d != '0) begin
                        mask_q   <= pending_d;
                        idx_q    <= next_idx_d;
                        osc_en_q <= ONE_HOT0 << next_idx_d;
                        timer_q  <= SETTLE_LOAD;
                        state_q  <= ST_SETTLE;
                     end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign osc_en_o       = osc_en_q;
   assign busy_o         = busy_q;
   assign result_valid_o = valid_q;
   assign result_idx_o   = idx_q;
   assign result_cnt_o   = cnt_q;
   assign done_o         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_ringosc_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sc_ringosc_meas_ctrl                                      |
// | Description : Self-checking bench for sc_ringosc_meas_ctrl. Rings are      |
// |               modelled as ideal square waves of integer CLK period; the    |
// |               expected result of each sweep is derived from the mask and   |
// |               the gate length alone.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sc_ringosc_meas_ctrl;

   localparam int SETTLE = 16;
   localparam int MAXC   = (1 << 20) - 1;
   localparam int MAXS   = 15;
   localparam int LIMIT  = 20000;

   logic        clk, rst_n, start, abort, ready;
   logic [7:0]  mask, osc;
   logic [15:0] gate;

   logic [7:0]  en, s_en;
   logic        busy, valid, done, s_busy, s_valid, s_done;
   logic [2:0]  idx, s_idx;
   logic [19:0] cnt;
   logic [3:0]  s_cnt;

   sc_ringosc_meas_ctrl u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .mask_i(mask), .gate_cycles_i(gate), .osc_i(osc), .osc_en_o(en),
      .busy_o(busy), .result_valid_o(valid), .result_ready_i(ready),
      .result_idx_o(idx), .result_cnt_o(cnt), .done_o(done));

   // Narrow-counter instance sharing all stimulus, for saturation.
   sc_ringosc_meas_ctrl #(.CNT_W(4)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .mask_i(mask), .gate_cycles_i(gate), .osc_i(osc), .osc_en_o(s_en),
      .busy_o(s_busy), .result_valid_o(s_valid), .result_ready_i(ready),
      .result_idx_o(s_idx), .result_cnt_o(s_cnt), .done_o(s_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ring models: rising edge exactly every per[k] clocks.
   int per [8];
   int tick = 0;
   always @(negedge clk) begin
      tick++;
      for (int k = 0; k < 8; k++)
         osc[k] <= (per[k] >= 4) && ((tick % per[k]) < (per[k] / 2));
   end

   // Monitor
   int got_idx[$], got_cnt[$], got_sat[$], runs[$];
   int done_seen, twohot, vlate, en_run;
   logic [7:0] prev_en;
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) begin
            got_idx.push_back(int'(idx));
            got_cnt.push_back(int'(cnt));
            got_sat.push_back(int'(s_cnt));
         end
         if (done) done_seen++;
         if ($countones(en) > 1) twohot++;
         if (en != 8'h00) begin
            if (prev_en != 8'h00 && en != prev_en) twohot++;
            en_run++;
         end else if (prev_en != 8'h00) begin
            runs.push_back(en_run);
            en_run = 0;
            if (!valid) vlate++;
         end
         prev_en = en;
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clear_mon();
      got_idx.delete(); got_cnt.delete(); got_sat.delete(); runs.delete();
      done_seen = 0; twohot = 0; vlate = 0; en_run = 0; prev_en = 8'h00;
   endtask

   task automatic wait_done(input string name);
      int c = 0;
      while (done_seen == 0 && c < LIMIT) begin
         @(posedge clk); #1;
         c++;
      end
      chk({name, "_timeout"}, c < LIMIT, 1);
   endtask

   // Full sweep against the reference: each set mask bit, ascending, gives
   // one result whose count is the number of ring periods in the window.
   task automatic run_sweep(input string name, input logic [7:0] m, input int g,
                            input bit rnd_ready, input bit restart);
      int geff, c, n;
      int e_idx[$], e_lo[$], e_hi[$], s_lo[$], s_hi[$];
      logic [7:0] e_first;
      geff = (g == 0) ? 1 : g;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            e_idx.push_back(i);
            e_lo.push_back((geff / per[i]) > MAXC ? MAXC : geff / per[i]);
            e_hi.push_back(((geff + per[i] - 1) / per[i]) > MAXC ? MAXC : (geff + per[i] - 1) / per[i]);
            s_lo.push_back((geff / per[i]) > MAXS ? MAXS : geff / per[i]);
            s_hi.push_back(((geff + per[i] - 1) / per[i]) > MAXS ? MAXS : (geff + per[i] - 1) / per[i]);
         end
      end
      e_first = m & (~m + 8'd1);
      clear_mon();
      @(posedge clk); #1;
      mask = m; gate = 16'(g); start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mask = 8'($urandom); gate = 16'($urandom);
      chk({name, "_busy_rise"}, busy, m != 8'h00);
      chk({name, "_first_en"}, en, e_first);
      c = 0;
      while (done_seen == 0 && c < LIMIT) begin
         @(posedge clk); #1;
         c++;
         if (rnd_ready) ready = 1'($urandom_range(0, 1));
         if (restart && c == 5) begin
            start = 1'b1; mask = 8'hFF; gate = 16'd3;
         end else begin
            start = 1'b0;
         end
      end
      ready = 1'b1;
      chk({name, "_timeout"}, c < LIMIT, 1);
      chk({name, "_done_once"}, done_seen, 1);
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_busy_end"}, busy, 0);
      chk({name, "_nresults"}, got_idx.size(), e_idx.size());
      chk({name, "_nruns"}, runs.size(), e_idx.size());
      chk({name, "_overlap"}, twohot, 0);
      chk({name, "_valid_align"}, vlate, 0);
      n = (got_idx.size() < e_idx.size()) ? got_idx.size() : e_idx.size();
      for (int i = 0; i < n; i++) begin
         chk({name, "_idx"}, got_idx[i], e_idx[i]);
         chk_rng({name, "_cnt"}, got_cnt[i], e_lo[i], e_hi[i]);
         chk_rng({name, "_satcnt"}, got_sat[i], s_lo[i], s_hi[i]);
         if (i < runs.size()) chk({name, "_en_len"}, runs[i], SETTLE + geff);
      end
   endtask

   typedef struct {
      logic [7:0] m;
      int         g;
      int         p;
      int         exp_n;
      int         exp_cnt;
      int         exp_len;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int w;
      int cap_idx, cap_cnt, bad;

      vecs[0] = '{8'h04, 100, 10, 1, 10, 116};
      vecs[1] = '{8'h01,  64,  4, 1, 16,  80};
      vecs[2] = '{8'hA0,  30,  6, 2,  5,  46};
      vecs[3] = '{8'h0F,  40,  8, 4,  5,  56};
      vecs[4] = '{8'h00,  50,  5, 0,  0,   0};

      for (int k = 0; k < 8; k++) per[k] = 8;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
      mask = 8'h00; gate = 16'd0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_en", en, 0);
      chk("reset_busy", busy, 0);
      chk("reset_valid", valid, 0);
      chk("reset_idx", idx, 0);
      chk("reset_cnt", cnt, 0);
      chk("reset_done", done, 0);
      rst_n = 1'b1;

      // Table-driven sweeps, all rings at the same period.
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < 8; k++) per[k] = vecs[v].p;
         run_sweep("vec", vecs[v].m, vecs[v].g, 1'b0, 1'b0);
         chk("vec_n", got_idx.size(), vecs[v].exp_n);
         if (got_cnt.size() > 0) chk("vec_cnt", got_cnt[0], vecs[v].exp_cnt);
         if (runs.size() > 0) chk("vec_len", runs[0], vecs[v].exp_len);
      end

      // Two rings at different rates.
      per[0] = 8; per[7] = 20;
      run_sweep("mask81", 8'h81, 200, 1'b0, 1'b0);
      if (got_idx.size() == 2) begin
         chk("mask81_c0", got_cnt[0], 25);
         chk("mask81_i1", got_idx[1], 7);
         chk("mask81_c1", got_cnt[1], 10);
      end

      // Saturation of the narrow counter and gate length zero.
      for (int k = 0; k < 8; k++) per[k] = 4;
      run_sweep("sat", 8'h01, 256, 1'b0, 1'b0);
      if (got_sat.size() == 1) begin
         chk("sat_wide", got_cnt[0], 64);
         chk("sat_narrow", got_sat[0], 15);
      end
      run_sweep("gate0", 8'h02, 0, 1'b0, 1'b0);
      if (runs.size() == 1) chk("gate0_len", runs[0], SETTLE + 1);

      // START while busy is ignored; MASK/GATE changes mid-sweep no effect.
      for (int k = 0; k < 8; k++) per[k] = 6;
      run_sweep("restart", 8'h01, 24, 1'b0, 1'b1);

      // READY held low 50 cycles in REPORT.
      for (int k = 0; k < 8; k++) per[k] = 5;
      clear_mon();
      @(posedge clk); #1;
      mask = 8'h06; gate = 16'd40; start = 1'b1; ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      w = 0;
      while (valid !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("hold_reach", w < 2000, 1);
      cap_idx = int'(idx); cap_cnt = int'(cnt);
      chk("hold_idx", cap_idx, 1);
      chk("hold_cnt", cap_cnt, 8);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (valid !== 1'b1 || int'(idx) != cap_idx || int'(cnt) != cap_cnt || en != 8'h00) bad++;
      end
      chk("hold_stable", bad, 0);
      @(posedge clk); #1;
      ready = 1'b1;
      wait_done("hold");
      chk("hold_nresults", got_idx.size(), 2);

      // ABORT during GATE of ring 3.
      for (int k = 0; k < 8; k++) per[k] = 6;
      clear_mon();
      @(posedge clk); #1;
      mask = 8'hFF; gate = 16'd100; start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      w = 0;
      while (en !== 8'h08 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("abort_reach", w < 2000, 1);
      repeat (SETTLE + 10) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_en", en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_valid", valid, 0);
      repeat (30) @(negedge clk);
      chk("abort_nodone", done_seen, 0);
      chk("abort_nresults", got_idx.size(), 3);
      chk("abort_idle_valid", valid, 0);
      run_sweep("after_abort", 8'h10, 48, 1'b0, 1'b0);

      // Reset mid-SETTLE drops everything without a clock edge.
      per[2] = 8;
      @(posedge clk); #1;
      mask = 8'h04; gate = 16'd40; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_en", en, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_idx", idx, 0);
      chk("rst_mid_valid", valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Randomised sweeps; periods chosen so most gates span whole periods.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
               0:       per[k] = 4;
               1:       per[k] = 6;
               2:       per[k] = 8;
               default: per[k] = 12;
            endcase
         end
         run_sweep("rand", 8'($urandom_range(0, 255)), 24 * $urandom_range(1, 4), 1'b1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
